// File: rtl/prbs_led_ctrl.sv
// Button-stepped PRBS pattern generator driving an LED bank.
// Each button press cycles OFF -> PRBS7 -> PRBS15 -> PRBS31 -> OFF.
module prbs_led_ctrl #(
    parameter int unsigned DIV_CNT = 20,
    parameter int unsigned LED_W   = 8,
    parameter logic [30:0] SEED    = 31'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             step
);

    typedef enum logic [1:0] {
        ModeOff    = 2'd0,
        ModePrbs7  = 2'd1,
        ModePrbs15 = 2'd2,
        ModePrbs31 = 2'd3
    } mode_e;

    mode_e              mode_q, mode_d, mode_next;
    logic               btn_q;
    logic               armed_q;
    logic [DIV_CNT-1:0] div_q, div_d;
    logic [30:0]        lfsr_q, lfsr_d;
    logic [30:0]        act_mask;
    logic               step_q, step_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               press;
    logic               tick;
    logic               fb;

    function automatic logic [30:0] width_mask(input mode_e m);
        logic [30:0] msk;
        msk = '0;
        case (m)
            ModePrbs7:  msk = 31'h0000_007F;
            ModePrbs15: msk = 31'h0000_7FFF;
            ModePrbs31: msk = 31'h7FFF_FFFF;
            default:    msk = '0;
        endcase
        return msk;
    endfunction

    // Seed loaded when entering a mode; an all-zero masked seed would lock the LFSR.
    function automatic logic [30:0] seed_for(input mode_e m);
        logic [30:0] s;
        if (m == ModeOff) begin
            s = SEED;
        end else begin
            s = SEED & width_mask(m);
            if (s == '0) begin
                s = 31'h0000_0001;
            end
        end
        return s;
    endfunction

    // armed_q blocks a press on the first edge after reset release, so a
    // button held through reset must be released before it counts.
    assign press = btn & ~btn_q & armed_q;
    assign tick  = (div_q == '1) && (mode_q != ModeOff);

    assign act_mask = width_mask(mode_q);

    always_comb begin
        fb = 1'b0;
        case (mode_q)
            ModePrbs7:  fb = lfsr_q[6] ^ lfsr_q[5];
            ModePrbs15: fb = lfsr_q[14] ^ lfsr_q[13];
            ModePrbs31: fb = lfsr_q[30] ^ lfsr_q[27];
            default:    fb = 1'b0;
        endcase
    end

    always_comb begin
        mode_next = ModeOff;
        case (mode_q)
            ModeOff:    mode_next = ModePrbs7;
            ModePrbs7:  mode_next = ModePrbs15;
            ModePrbs15: mode_next = ModePrbs31;
            ModePrbs31: mode_next = ModeOff;
            default:    mode_next = ModeOff;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        div_d  = div_q;
        lfsr_d = lfsr_q;
        step_d = 1'b0;
        led_d  = '0;

        if (press) begin
            mode_d = mode_next;
            div_d  = '0;
            lfsr_d = seed_for(mode_next);
        end else begin
            if (mode_q == ModeOff) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_CNT'(1);
            end
            if (tick) begin
                step_d = 1'b1;
                if ((lfsr_q & act_mask) == '0) begin
                    lfsr_d = seed_for(mode_q);
                end else begin
                    lfsr_d = {lfsr_q[29:0], fb} & act_mask;
                end
            end
        end

        if (mode_q != ModeOff) begin
            led_d = lfsr_q[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= ModeOff;
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
            div_q   <= '0;
            lfsr_q  <= SEED;
            step_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            btn_q   <= btn;
            armed_q <= 1'b1;
            div_q   <= div_d;
            lfsr_q  <= lfsr_d;
            step_q  <= step_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule

// File: tb/tb_prbs_led_ctrl.sv
// Directed bench for prbs_led_ctrl with DIV_CNT=2, LED_W=7; a second
// instance uses SEED=0 to exercise the zero-seed override.
module tb_prbs_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       btn2;
    logic [6:0] led, led2;
    logic [1:0] mode, mode2;
    logic       step, step2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prbs_led_ctrl #(.DIV_CNT(2), .LED_W(7), .SEED(31'h0000_0001)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .led   (led),
        .mode  (mode),
        .step  (step)
    );

    prbs_led_ctrl #(.DIV_CNT(2), .LED_W(7), .SEED(31'h0000_0000)) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn2),
        .led   (led2),
        .mode  (mode2),
        .step  (step2)
    );

    typedef struct {
        logic       btn;
        logic [1:0] mode;
        logic [6:0] led;
        logic       step;
    } vec_t;

    vec_t       vecs[34];
    logic [6:0] seq[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc1;
        @(posedge clk);
        #1;
    endtask

    task automatic press1;
        btn = 1'b1;
        cyc1();
        btn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  steps;
        int  last;
        int  cyc;
        int  first_ret;
        int  bad;
        int  distinct;
        int  zeros;
        bit  prev;
        bit  spacing_ok;
        bit  seen[128];

        rst_n = 1'b0;
        btn   = 1'b0;
        btn2  = 1'b0;
        #12;
        check("reset mode", 32'(mode), 32'd0);
        check("reset led", 32'(led), 32'd0);
        check("reset step", 32'(step), 32'd0);
        check("reset lfsr", 32'(dut.lfsr_q), 32'd1);
        check("reset div", 32'(dut.div_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc1();
        check("idle mode", 32'(mode), 32'd0);

        // Press, then 8 PRBS7 steps; the divider steps every 4 cycles.
        seq = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03, 7'h06};
        for (int k = 0; k < 34; k++) begin
            vecs[k].btn  = (k < 10);
            vecs[k].mode = 2'd1;
            vecs[k].step = (k > 0) && (k % 4 == 0);
            vecs[k].led  = (k == 0) ? 7'h00 : seq[(k - 1) / 4];
        end
        for (int k = 0; k < 34; k++) begin
            btn = vecs[k].btn;
            cyc1();
            check($sformatf("vec%0d mode", k), 32'(mode), 32'(vecs[k].mode));
            check($sformatf("vec%0d led", k), 32'(led), 32'(vecs[k].led));
            check($sformatf("vec%0d step", k), 32'(step), 32'(vecs[k].step));
        end

        // Continue to step 127: led must first return to 0x01 there.
        steps      = 8;
        last       = 32;
        cyc        = 33;
        first_ret  = 0;
        prev       = 1'b0;
        spacing_ok = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cyc1();
            cyc++;
            if (prev) begin
                prev = 1'b0;
                if (led == 7'h01 && first_ret == 0) first_ret = steps;
                if (steps == 127) break;
            end
            if (step) begin
                if (cyc - last != 4) spacing_ok = 1'b0;
                last = cyc;
                steps++;
                prev = 1'b1;
            end
        end
        check("prbs7 steps reached", 32'(steps), 32'd127);
        check("prbs7 period", 32'(first_ret), 32'd127);
        check("step spacing", 32'(spacing_ok), 32'd1);

        // Three more presses: 2, 3, 0.
        press1();
        check("press->prbs15 mode", 32'(mode), 32'd2);
        cyc1();
        check("prbs15 seed led", 32'(led), 32'h01);
        press1();
        check("press->prbs31 mode", 32'(mode), 32'd3);
        cyc1();
        check("prbs31 seed led", 32'(led), 32'h01);
        press1();
        check("press->off mode", 32'(mode), 32'd0);
        cyc1();
        check("off led", 32'(led), 32'h00);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            cyc1();
            if (led != 7'h00 || step != 1'b0 || dut.div_q != 2'd0 || mode != 2'd0) bad++;
        end
        check("off idle bad cycles", 32'(bad), 32'd0);

        // Press coinciding with a tick: press wins, no step, seed reloaded.
        press1();
        check("coinc pre mode", 32'(mode), 32'd1);
        cyc1();
        cyc1();
        cyc1();
        check("coinc div at tick", 32'(dut.div_q), 32'd3);
        press1();
        check("coinc mode", 32'(mode), 32'd2);
        check("coinc step", 32'(step), 32'd0);
        check("coinc lfsr", 32'(dut.lfsr_q), 32'd1);
        cyc1();
        check("coinc step next", 32'(step), 32'd0);
        check("coinc led", 32'(led), 32'h01);

        // Mid-sequence PRBS15, then a reset pulse with btn held high.
        repeat (20) cyc1();
        check("prbs15 mid led", 32'(led), 32'h20);
        btn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst led", 32'(led), 32'd0);
        check("async rst mode", 32'(mode), 32'd0);
        check("async rst step", 32'(step), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc1();
            if (mode != 2'd0 || led != 7'h00) bad++;
        end
        check("held btn no press", 32'(bad), 32'd0);
        btn = 1'b0;
        cyc1();
        press1();
        check("press after release", 32'(mode), 32'd1);

        // SEED=0 instance: starts at 0x01 and covers 127 distinct nonzero values.
        btn2 = 1'b1;
        cyc1();
        btn2 = 1'b0;
        check("zseed mode", 32'(mode2), 32'd1);
        check("zseed lfsr", 32'(dut_z.lfsr_q), 32'd1);
        cyc1();
        check("zseed led", 32'(led2), 32'h01);
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        seen[1]  = 1'b1;
        distinct = 1;
        zeros    = 0;
        steps    = 0;
        prev     = 1'b0;
        for (int i = 0; i < 700; i++) begin
            cyc1();
            if (prev) begin
                prev = 1'b0;
                if (led2 == 7'h00) zeros++;
                if (!seen[led2]) begin
                    seen[led2] = 1'b1;
                    distinct++;
                end
                if (steps == 126) break;
            end
            if (step2) begin
                steps++;
                prev = 1'b1;
            end
        end
        check("zseed steps", 32'(steps), 32'd126);
        check("zseed distinct", 32'(distinct), 32'd127);
        check("zseed zeros", 32'(zeros), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
